// File: rtl/cr16_control_fsm_if.sv
// Control interface between the CR16 instruction controller (master) and
// the RF_ALU datapath (slave): instruction handshake, flags and decoded controls.
interface cr16_control_fsm_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) ();
    logic               instr_valid;
    logic [WIDTH-1:0]   instr;
    logic [7:0]         PSR;
    logic               instr_ready;
    logic               regWrite;
    logic               shiftOrALU;
    logic               alusrca;
    logic               alusrcb;
    logic               shiftType;
    logic [WIDTH-1:0]   shiftDirection;
    logic [REGBITS-1:0] aluControl;
    logic [REGBITS-1:0] regAddress1;
    logic [REGBITS-1:0] regAddress2;
    logic [WIDTH-1:0]   immediate;
    logic               jumpEN;
    logic               jalEN;
    logic               ALUselect;
    logic               pc_en;
    logic               illegal;

    modport master (
        input  instr_valid, instr, PSR,
        output instr_ready, regWrite, shiftOrALU, alusrca, alusrcb, shiftType,
               shiftDirection, aluControl, regAddress1, regAddress2, immediate,
               jumpEN, jalEN, ALUselect, pc_en, illegal
    );

    modport slave (
        output instr_valid, instr, PSR,
        input  instr_ready, regWrite, shiftOrALU, alusrca, alusrcb, shiftType,
               shiftDirection, aluControl, regAddress1, regAddress2, immediate,
               jumpEN, jalEN, ALUselect, pc_en, illegal
    );
endinterface

// File: rtl/cr16_control_fsm.sv
// Multicycle CR16 instruction controller: FETCH -> DECODE -> EXEC -> WB,
// Moore outputs decoded from the latched instruction register.
module cr16_control_fsm #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    cr16_control_fsm_if.master bus
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ir;
    logic             taken;

    logic [3:0] op, ext, rd, rs;
    assign op  = ir[15:12];
    assign rd  = ir[11:8];
    assign ext = ir[7:4];
    assign rs  = ir[3:0];

    logic unused_psr;
    assign unused_psr = ^{bus.PSR[7], bus.PSR[5:1]};

    function automatic logic [WIDTH-1:0] sext8(input logic [7:0] v);
        return {{(WIDTH-8){v[7]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] sext5(input logic [4:0] v);
        return {{(WIDTH-5){v[4]}}, v};
    endfunction

    function automatic logic cond_met(input logic [3:0] c, input logic [7:0] psr);
        case (c)
            4'b0000: return psr[6];
            4'b0001: return ~psr[6];
            4'b0010: return psr[0];
            4'b0011: return ~psr[0];
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Combinational decode of ir; gated onto the bus by state below.
    logic [REGBITS-1:0] dec_alu;
    logic               dec_srca, dec_srcb, dec_sel_alu;
    logic [WIDTH-1:0]   dec_shdir, dec_imm;
    logic               dec_wr, dec_jal, dec_jcond, dec_ill, imm_op;

    always_comb begin
        dec_alu     = '0;
        dec_srca    = 1'b0;
        dec_srcb    = 1'b0;
        dec_sel_alu = 1'b0;
        dec_shdir   = '0;
        dec_imm     = '0;
        dec_wr      = 1'b0;
        dec_jal     = 1'b0;
        dec_jcond   = 1'b0;
        dec_ill     = 1'b0;
        imm_op      = 1'b0;
        case (op)
            4'b0000: begin
                dec_alu     = REGBITS'(ext);
                dec_srca    = 1'b1;
                dec_sel_alu = 1'b1;
                dec_wr      = (ext != 4'b1011);
            end
            4'b0001, 4'b0010, 4'b0011: begin
                dec_imm = {{(WIDTH-8){1'b0}}, ir[7:0]};
                imm_op  = 1'b1;
            end
            4'b0101, 4'b1001, 4'b1011, 4'b1101: begin
                dec_imm = sext8(ir[7:0]);
                imm_op  = 1'b1;
            end
            4'b1111: begin
                dec_imm = {ir[7:0], {(WIDTH-8){1'b0}}};
                imm_op  = 1'b1;
            end
            4'b1000: begin
                if (ext == 4'b0100) begin
                    dec_srca = 1'b1;
                    dec_wr   = 1'b1;
                end else if (ext[3:1] == 3'b000) begin
                    // Odd 5-bit amount encoding: ir[0] doubles as the sign bit.
                    dec_srca  = 1'b1;
                    dec_srcb  = 1'b1;
                    dec_wr    = 1'b1;
                    dec_shdir = sext5({ir[0], rs});
                end else begin
                    dec_ill = 1'b1;
                end
            end
            4'b0100: begin
                if (ext == 4'b1000) begin
                    dec_jal = 1'b1;
                    dec_wr  = 1'b1;
                end else if (ext == 4'b1100) begin
                    dec_jcond = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
        if (imm_op) begin
            dec_alu     = REGBITS'(op);
            dec_srca    = 1'b1;
            dec_srcb    = 1'b1;
            dec_sel_alu = 1'b1;
            dec_wr      = (op != 4'b1011);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ir    <= '0;
            taken <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && bus.instr_valid)
                ir <= bus.instr;
            // Branch decision is frozen at the end of EXEC so PSR changes in WB are ignored.
            if (state == EXEC)
                taken <= dec_jcond & cond_met(rd, bus.PSR);
        end
    end

    always_comb begin
        state_nxt          = state;
        bus.instr_ready    = 1'b0;
        bus.regWrite       = 1'b0;
        bus.shiftOrALU     = 1'b0;
        bus.alusrca        = 1'b0;
        bus.alusrcb        = 1'b0;
        bus.shiftType      = 1'b0;
        bus.shiftDirection = '0;
        bus.aluControl     = '0;
        bus.regAddress1    = '0;
        bus.regAddress2    = '0;
        bus.immediate      = '0;
        bus.jumpEN         = 1'b0;
        bus.jalEN          = 1'b0;
        bus.ALUselect      = 1'b0;
        bus.pc_en          = 1'b0;
        bus.illegal        = 1'b0;
        case (state)
            FETCH: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid)
                    state_nxt = DECODE;
            end
            default: begin
                bus.regAddress1    = REGBITS'(rd);
                bus.regAddress2    = REGBITS'(rs);
                bus.aluControl     = dec_alu;
                bus.alusrca        = dec_srca;
                bus.alusrcb        = dec_srcb;
                bus.shiftOrALU     = dec_sel_alu;
                bus.shiftDirection = dec_shdir;
                bus.immediate      = dec_imm;
                bus.ALUselect      = dec_jal;
                case (state)
                    DECODE:  state_nxt = EXEC;
                    EXEC:    state_nxt = WB;
                    default: begin
                        state_nxt    = FETCH;
                        bus.regWrite = dec_wr;
                        bus.jumpEN   = dec_jal | (dec_jcond & taken);
                        bus.jalEN    = dec_jal;
                        bus.pc_en    = 1'b1;
                        bus.illegal  = dec_ill;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Scoreboard bench for cr16_control_fsm: driver pushes reference-model
// expectations, a negedge monitor compares every cycle of every instruction.
module tb_cr16_control_fsm;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cr16_control_fsm_if #(.WIDTH(16), .REGBITS(4)) bus ();
    cr16_control_fsm #(.WIDTH(16), .REGBITS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [31:0] hs;
        logic [3:0]  ra1, ra2, alu;
        logic        srca, srcb, sel_alu, link;
        logic [15:0] shdir, imm;
        logic        wr, jump, jal, ill;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (reset) sb.delete();

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: what the datapath must see for word w when PSR during EXEC is psr.
    function automatic exp_t model(input logic [15:0] w, input logic [7:0] psr);
        exp_t e;
        int op, ext, cond, v;
        e = '0;
        op = int'(w[15:12]); ext = int'(w[7:4]); cond = int'(w[11:8]);
        e.ra1 = w[11:8];
        e.ra2 = w[3:0];
        if (op == 0) begin
            e.alu = w[7:4]; e.srca = 1; e.sel_alu = 1; e.wr = (ext != 11);
        end else if (op inside {1, 2, 3, 5, 9, 11, 13, 15}) begin
            v = int'(w[7:0]);
            if (op inside {5, 9, 11, 13} && v > 127) v = v - 256;
            if (op == 15) v = v * 256;
            e.imm = 16'(v);
            e.alu = w[15:12]; e.srca = 1; e.srcb = 1; e.sel_alu = 1; e.wr = (op != 11);
        end else if (op == 8 && ext == 4) begin
            e.srca = 1; e.wr = 1;
        end else if (op == 8 && ext <= 1) begin
            v = int'(w[3:0]) + (w[0] ? 16 : 0);
            if (v >= 16) v = v - 32;
            e.shdir = 16'(v);
            e.srca = 1; e.srcb = 1; e.wr = 1;
        end else if (op == 4 && ext == 8) begin
            e.jump = 1; e.jal = 1; e.link = 1; e.wr = 1;
        end else if (op == 4 && ext == 12) begin
            case (cond)
                0:  e.jump = psr[6];
                1:  e.jump = !psr[6];
                2:  e.jump = psr[0];
                3:  e.jump = !psr[0];
                14: e.jump = 1;
                default: e.jump = 0;
            endcase
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    // Monitor: idle outputs in FETCH, held fields and WB-only strobes otherwise.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (bus.instr_ready) begin
                chk("fetch_idle",
                    {bus.regWrite, bus.shiftOrALU, bus.alusrca, bus.alusrcb, bus.shiftType,
                     bus.shiftDirection, bus.aluControl, bus.regAddress1, bus.regAddress2,
                     bus.immediate, bus.jumpEN, bus.jalEN, bus.ALUselect, bus.pc_en, bus.illegal},
                    64'd0);
                if (sb.size() > 0 && cyc >= int'(sb[0].hs)) begin
                    chk("early_fetch", 64'(cyc - int'(sb[0].hs)), 64'd3);
                    void'(sb.pop_front());
                end
            end else if (sb.size() == 0) begin
                chk("busy_without_instr", {63'd0, bus.instr_ready}, 64'd1);
            end else begin
                exp_t e;
                int age;
                e = sb[0];
                age = cyc - int'(e.hs);
                chk("fields",
                    {bus.regAddress1, bus.regAddress2, bus.aluControl, bus.alusrca, bus.alusrcb,
                     bus.shiftOrALU, bus.shiftType, bus.shiftDirection, bus.immediate, bus.ALUselect},
                    {e.ra1, e.ra2, e.alu, e.srca, e.srcb, e.sel_alu, 1'b0, e.shdir, e.imm, e.link});
                chk("strobes",
                    {bus.regWrite, bus.jumpEN, bus.jalEN, bus.pc_en, bus.illegal},
                    (age == 2) ? {e.wr, e.jump, e.jal, 1'b1, e.ill} : 5'd0);
                if (age > 2) chk("wb_latency", 64'(age), 64'd2);
                if (age >= 2) void'(sb.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input logic [15:0] w, input logic [7:0] psr_exec, input int idle);
        repeat (idle) begin
            @(negedge clk);
            bus.instr_valid = 1'b0; bus.instr = 16'($urandom); bus.PSR = 8'($urandom);
        end
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.instr = w; bus.PSR = 8'($urandom);
        wait_ready();
        begin
            exp_t e;
            e = model(w, psr_exec);
            e.hs = 32'(cyc + 1);
            sb.push_back(e);
        end
        @(negedge clk);  // DECODE: junk valid words must be ignored
        bus.instr_valid = 1'($urandom); bus.instr = 16'($urandom); bus.PSR = 8'($urandom);
        @(negedge clk);  // EXEC
        bus.PSR = psr_exec;
        @(negedge clk);  // WB
        bus.PSR = 8'($urandom); bus.instr_valid = 1'b0;
    endtask

    logic [3:0] legal_ops [0:9];

    initial begin
        logic [15:0] w;
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF, 4'h0};
        reset = 1'b1; bus.instr_valid = 1'b0; bus.instr = '0; bus.PSR = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        issue(16'h0112, 8'h00, 0);
        issue(16'h53FF, 8'h00, 0);
        issue(16'h13FF, 8'h00, 1);
        issue(16'hF3AB, 8'h00, 0);
        issue(16'hB305, 8'h00, 0);
        issue(16'h831F, 8'h00, 0);
        issue(16'h8341, 8'h00, 0);
        issue(16'h40C5, 8'h40, 0);
        issue(16'h40C5, 8'h00, 0);
        issue(16'h4EC0, 8'h00, 0);
        issue(16'h4385, 8'h00, 2);
        issue(16'h7000, 8'h00, 0);

        // Reset during EXEC of an ADD aborts it with no WB strobes.
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.instr = 16'h0152;
        wait_ready();
        begin
            exp_t e;
            e = model(16'h0152, 8'h00);
            e.hs = 32'(cyc + 1);
            sb.push_back(e);
        end
        @(negedge clk); bus.instr_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", {63'd0, bus.instr_ready}, 64'd1);
        chk("abort_no_wb", {bus.regWrite, bus.pc_en}, 64'd0);

        for (int i = 0; i < 160; i++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: w[15:12] = legal_ops[$urandom_range(0, 9)];
                2: begin
                    w[15:12] = 4'h4;
                    w[7:4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 1) ? 4'h8 : 4'hC);
                    if ($urandom_range(0, 1) == 1) w[11:8] = 4'($urandom_range(0, 3));
                    else if ($urandom_range(0, 1) == 1) w[11:8] = 4'hE;
                end
                default: begin
                    w[15:12] = 4'h8;
                    w[7:4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1) == 1 ? 4 : $urandom_range(0, 1));
                end
            endcase
            issue(w, 8'($urandom), $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
Multicycle instruction controller that drives the control interface of the RF_ALU datapath. It is the initiator side of that interface. It accepts 16-bit instruction words through a valid/ready handshake and decodes each one. It then sequences the datapath controls through DECODE, EXEC and WB states, one instruction per 4 cycles.

Parameters:
WIDTH, 16, instruction/immediate/shiftDirection width
REGBITS, 4, register address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instr holds a valid instruction word
instr  input  WIDTH  instruction: [15:12] op, [11:8] Rdest/cond, [7:4] opext/imm_hi, [3:0] Rsrc/imm_lo
PSR  input  8  datapath flags: [0] C, [2] L, [5] F, [6] Z, [7] N
instr_ready  output  1  high in FETCH; a word is consumed when instr_valid && instr_ready
regWrite  output  1  register file write enable
shiftOrALU  output  1  1 = ALU result, 0 = shifter result
alusrca  output  1  1 = A operand from regAddress1
alusrcb  output  1  1 = B operand from immediate, 0 = from regAddress2
shiftType  output  1  0 = logical (the only type issued)
shiftDirection  output  WIDTH  signed shift amount; positive = left
aluControl  output  REGBITS  ALU operation code
regAddress1  output  REGBITS  Rdest (A operand and write target)
regAddress2  output  REGBITS  Rsrc
immediate  output  WIDTH  extended immediate
jumpEN  output  1  PC loads target
jalEN  output  1  link value written to Rdest
ALUselect  output  1  1 = writeback from link path
pc_en  output  1  PC update strobe
illegal  output  1  1-cycle pulse in WB for an undecodable word

Behaviour:
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH.
- FETCH waits until instr_valid && instr_ready. On that edge, instr is latched into ir and the FSM moves to DECODE.
- DECODE, EXEC and WB each advance unconditionally after one cycle. Throughput is 1 instruction per 4 cycles.
- Outputs are Moore: a function of state and ir only.
- In FETCH, every output except instr_ready = 1 is 0.
- Decoded fields are driven from DECODE through WB inclusive and held constant: regAddress1/2, aluControl, alusrca/b, shiftOrALU, shiftType, shiftDirection, immediate.
- regWrite, jumpEN, jalEN, pc_en and illegal assert only in WB.
- pc_en = 1 in WB for every instruction, including illegal ones.
- Reset: state = FETCH, ir = 0, all outputs 0 except instr_ready = 1 on the cycle after reset. Reset in any state aborts the instruction with no WB strobes.
- Decode, op = 0000 (R-type): aluControl = ir[7:4], alusrcb = 0, shiftOrALU = 1, alusrca = 1. regWrite = 1 except when opext = 1011 (CMP).
- Decode, op in {0001 ANDI, 0010 ORI, 0011 XORI}: immediate = zero-extended ir[7:0].
- Decode, op in {0101 ADDI, 1001 SUBI, 1011 CMPI, 1101 MOVI}: immediate = sign-extended ir[7:0].
- Decode, op = 1111 LUI: immediate = {ir[7:0], 8'h00}.
- For all immediate ALU ops: aluControl = op, alusrcb = 1, shiftOrALU = 1, alusrca = 1, regWrite = 1 except CMPI.
- Decode, op = 1000 (shift): shiftOrALU = 0, shiftType = 0.
  - opext 0100 (LSH): alusrcb = 0, amount taken from Rsrc.
  - opext 000x (LSHI): alusrcb = 1, shiftDirection = sign-extended {ir[0], ir[3:0]} (5-bit signed amount, range -16..15).
  - regWrite = 1.
- Decode, op = 0100, opext = 1000 (JAL): jumpEN = 1, jalEN = 1, ALUselect = 1, regWrite = 1 in WB. Target register is Rsrc.
- Decode, op = 0100, opext = 1100 (Jcond): cond = ir[11:8], evaluated on PSR during EXEC and registered as taken at the end of EXEC.
  - Conditions: 0000 EQ Z=1; 0001 NE Z=0; 0010 CS C=1; 0011 CC C=0; 1110 UC always.
  - Any other cond is never taken.
  - jumpEN = taken in WB; regWrite = 0.
- Any other encoding is illegal: treated as a NOP with no regWrite/jumpEN and illegal = 1 in WB.
- instr_valid asserted outside FETCH is ignored; the word is not consumed.

Test Plan:
- Reset held 2 cycles, then released with instr_valid = 0 -> FSM stays in FETCH, instr_ready = 1, all other outputs 0, and no pc_en.
- R-type AND, instr = 16'h0112 with valid held -> regAddress1 = 1, regAddress2 = 2, aluControl = 0001, alusrcb = 0. regWrite = 1 and pc_en = 1 only in the 4th cycle after the handshake; instr_ready returns high on the 5th cycle.
- Immediates -> ADDI 16'h53FF gives immediate = 16'hFFFF; ANDI 16'h13FF gives 16'h00FF; LUI 16'hF3AB gives 16'hAB00. CMPI 16'hB305 gives regWrite = 0 in WB.
- LSHI 16'h831F -> shiftOrALU = 0, alusrcb = 1, shiftDirection = 16'hFFFF, regWrite = 1 in WB.
- Jcond EQ 16'h40C5 with PSR[6] = 1 during EXEC -> jumpEN = 1 in WB. The same word with PSR[6] = 0 -> jumpEN = 0. JAL 16'h4385 -> jalEN = 1, ALUselect = 1, regWrite = 1.
- Illegal word 16'h7000 -> illegal pulse and pc_en in WB, regWrite = 0. Reset asserted during EXEC of an ADD -> no regWrite, FETCH state on the next cycle.
